// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, transfer sizes and size helpers for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    function automatic logic size_ok(input logic [3:0] s);
        return s == SZ_B || s == SZ_H || s == SZ_W || s == SZ_D;
    endfunction

    function automatic logic [7:0] byte_mask(input logic [3:0] s);
        return s == SZ_D ? 8'hFF : s == SZ_W ? 8'h0F : s == SZ_H ? 8'h03 : s == SZ_B ? 8'h01 : 8'h00;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: byte storage with an 8-byte combinational read port and per-byte clocked writes
module dmem_byte_array #(
    parameter int DEPTH_BYTES = 1024,
    localparam int AW = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    we,
    input  logic [63:0]   wdata
);

    logic [7:0] mem [DEPTH_BYTES];

    // Lane addresses wrap at the top; out-of-range lanes are masked or rejected upstream.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++)
            if (we[k]) mem[waddr + AW'(k)] <= wdata[8*k +: 8];
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < 8; k++)
            rdata[8*k +: 8] = mem[raddr + AW'(k)];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory behind req/rsp valid-ready handshakes.
// Define DMEM_ALIGN_CHECK_EN to reject accesses whose address is not a multiple of the size.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    dmem_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [63:0]   a_addr, a_wdata;
    logic          a_write;
    logic [3:0]    a_size;
    logic [63:0]   x_addr, x_wdata, rd, rd_mask;
    logic [3:0]    x_size;
    logic [7:0]    bm, we;
    logic          accept, exec, x_write, x_err, bad_align;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign accept    = req_valid & req_ready;

    // With LATENCY=1 the access executes on the accept edge, so it must use the live inputs.
    assign x_addr  = state == IDLE ? req_addr  : a_addr;
    assign x_wdata = state == IDLE ? req_wdata : a_wdata;
    assign x_write = state == IDLE ? req_write : a_write;
    assign x_size  = state == IDLE ? req_size  : a_size;
    assign exec    = (state == BUSY && cnt == '0) || (accept && LATENCY == 1);

`ifdef DMEM_ALIGN_CHECK_EN
    assign bad_align = (x_addr[3:0] & (x_size - 4'd1)) != 4'd0;
`else
    assign bad_align = 1'b0;
`endif

    assign x_err = !size_ok(x_size) || ({1'b0, x_addr} + {61'd0, x_size} > 65'(DEPTH_BYTES)) || bad_align;
    assign bm    = byte_mask(x_size);
    assign we    = (rst && exec && x_write && !x_err) ? bm : 8'd0;

    for (genvar i = 0; i < 8; i++) begin : g_mask
        assign rd_mask[8*i +: 8] = {8{bm[i]}};
    end

    dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
        .clk   (clk),
        .raddr (x_addr[AW-1:0]),
        .rdata (rd),
        .waddr (x_addr[AW-1:0]),
        .we    (we),
        .wdata (x_wdata)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: if (accept) begin
                state_n = LATENCY == 1 ? RESP : BUSY;
                cnt_n   = CW'(LATENCY - 1);
            end
            BUSY: begin
                state_n = cnt == '0 ? RESP : BUSY;
                cnt_n   = cnt == '0 ? cnt : cnt - 1'b1;
            end
            RESP: state_n = rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_addr    <= '0;
            a_wdata   <= '0;
            a_write   <= 1'b0;
            a_size    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                a_addr  <= req_addr;
                a_wdata <= req_wdata;
                a_write <= req_write;
                a_size  <= req_size;
            end
            if (exec) begin
                rsp_rdata <= (x_write || x_err) ? '0 : rd & rd_mask;
                rsp_err   <= x_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed store/load vectors with hand-computed results for dmem_responder
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  req_size = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [63:0] rd;
    logic        e;
    int          lat;

    dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // One transaction; rsp_ready is held low for `hold` cycles once the response is up.
    task automatic xfer(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [3:0] s,
                        input int hold, output logic [63:0] r, output logic er, output int l);
        @(negedge clk);
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_size  = s;
        rsp_ready = hold == 0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = '1;
        req_wdata = '1;
        req_size  = 4'd8;
        l = 0;
        while (!rsp_valid && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid never rose within 20 cycles");
        end
        r  = rsp_rdata;
        er = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {63'd0, rsp_valid}, 64'd1);
            check("hold_rdata", rsp_rdata, r);
            check("hold_req_ready", {63'd0, req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("back_idle_ready", {63'd0, req_ready}, 64'd1);
        check("back_idle_valid", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #12;
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err",   {63'd0, rsp_err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: store then load a doubleword
        xfer(1'b1, 64'h10, 64'h0123456789ABCDEF, 4'd8, 0, rd, e, lat);
        check("t1_st_lat", 64'(lat), 64'd2);
        check("t1_st_err", {63'd0, e}, 64'd0);
        check("t1_st_rd", rd, 64'd0);
        xfer(1'b0, 64'h10, 64'd0, 4'd8, 0, rd, e, lat);
        check("t1_ld_lat", 64'(lat), 64'd2);
        check("t1_ld_rd", rd, 64'h0123456789ABCDEF);
        check("t1_ld_err", {63'd0, e}, 64'd0);

        // 2: narrow loads zero-extend
        xfer(1'b0, 64'h12, 64'd0, 4'd2, 0, rd, e, lat);
        check("t2_half", rd, 64'h89AB);
        xfer(1'b0, 64'h17, 64'd0, 4'd1, 0, rd, e, lat);
        check("t2_byte", rd, 64'h01);
        xfer(1'b0, 64'h14, 64'd0, 4'd4, 0, rd, e, lat);
        check("t2_word", rd, 64'h01234567);

        // 3: back-pressure in RESP
        xfer(1'b0, 64'h10, 64'd0, 4'd8, 5, rd, e, lat);
        check("t3_rd", rd, 64'h0123456789ABCDEF);

        // 4: range and size errors
        xfer(1'b0, 64'(DEPTH - 4), 64'd0, 4'd8, 0, rd, e, lat);
        check("t4_range_err", {63'd0, e}, 64'd1);
        check("t4_range_rd", rd, 64'd0);
        xfer(1'b0, 64'(DEPTH - 8), 64'd0, 4'd8, 0, rd, e, lat);
        check("t4_top_ok_err", {63'd0, e}, 64'd0);
        xfer(1'b0, 64'h10, 64'd0, 4'd3, 0, rd, e, lat);
        check("t4_size_err", {63'd0, e}, 64'd1);
        check("t4_size_rd", rd, 64'd0);
        xfer(1'b1, 64'h3F8, 64'h0706050403020100, 4'd8, 0, rd, e, lat);
        xfer(1'b1, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFF, 4'd8, 0, rd, e, lat);
        check("t4_wrap_err", {63'd0, e}, 64'd1);
        xfer(1'b0, 64'h3F8, 64'd0, 4'd8, 0, rd, e, lat);
        check("t4_wrap_mem", rd, 64'h0706050403020100);

        // 5: misaligned store
        xfer(1'b1, 64'h20, 64'd0, 4'd8, 0, rd, e, lat);
        xfer(1'b1, 64'h21, 64'hDEADBEEF, 4'd4, 0, rd, e, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        check("t5_err", {63'd0, e}, 64'd1);
        xfer(1'b0, 64'h20, 64'd0, 4'd8, 0, rd, e, lat);
        check("t5_mem", rd, 64'd0);
`else
        check("t5_err", {63'd0, e}, 64'd0);
        xfer(1'b0, 64'h20, 64'd0, 4'd8, 0, rd, e, lat);
        check("t5_mem", rd, 64'h000000DEADBEEF00);
`endif

        // 6: reset during BUSY aborts an uncommitted store
        xfer(1'b1, 64'h40, 64'hAAAAAAAAAAAAAAAA, 4'd8, 0, rd, e, lat);
        xfer(1'b0, 64'h10, 64'd0, 4'd8, 0, rd, e, lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h40;
        req_wdata = 64'h5555555555555555;
        req_size  = 4'd8;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("t6_busy", {63'd0, req_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("t6_rst_ready", {63'd0, req_ready}, 64'd1);
        check("t6_rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("t6_rst_rdata", rsp_rdata, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        xfer(1'b0, 64'h40, 64'd0, 4'd8, 0, rd, e, lat);
        check("t6_mem", rd, 64'hAAAAAAAAAAAAAAAA);
        check("t6_err", {63'd0, e}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
